// File: rtl/demux_1x2_pkt_sel_if.sv
// demux_1x2_pkt_sel_if
//   Beat stream into the packet steering stage and the registered beat it
//   presents to the 1x2 demux, together with the per-branch consumer readies.
//   in_data/in_valid/in_last/in_ready : upstream valid/ready beat stream
//   i/s/valid_o/last_o                : registered beat, select and framing to demux
//   ready0/ready1                     : branch 0 (out1) / branch 1 (out2) ready
//   slave  : view taken by the steering stage
//   master : view taken by the upstream source / downstream consumers
interface demux_1x2_pkt_sel_if #(
   parameter int DW = 8
);
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_last;
   logic          in_ready;
   logic [DW-1:0] i;
   logic          s;
   logic          valid_o;
   logic          last_o;
   logic          ready0;
   logic          ready1;

   modport slave (
      input  in_data, in_valid, in_last, ready0, ready1,
      output in_ready, i, s, valid_o, last_o
   );

   modport master (
      output in_data, in_valid, in_last, ready0, ready1,
      input  in_ready, i, s, valid_o, last_o
   );
endinterface

// File: rtl/demux_1x2_pkt_sel.sv
// demux_1x2_pkt_sel
//   Packet steering stage in front of a 1x2 demux. Registers each accepted beat
//   (single register slice, 1 cycle latency, 1 beat/clk), picks a branch per
//   packet (round-robin or forced) and holds the select for the whole packet.
//   Packets longer than PKT_MAX beats are cut: the PKT_MAX-th beat is marked
//   last, the remainder is discarded and a sticky error is raised.
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : beat stream in, registered beat/select out, branch readies
//   mode, force_sel   : 0 = round-robin, 1 = use force_sel (sampled on first beat)
//   pkt_cnt0/pkt_cnt1 : wrapping count of packets completed per branch
//   pkt_err           : sticky truncation flag
module demux_1x2_pkt_sel #(
   parameter int DW      = 8,
   parameter int PKT_MAX = 16,
   parameter int CNT_W   = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   demux_1x2_pkt_sel_if.slave      bus,
   input  logic                    mode,
   input  logic                    force_sel,
   output logic [CNT_W-1:0]        pkt_cnt0,
   output logic [CNT_W-1:0]        pkt_cnt1,
   output logic                    pkt_err
);
   localparam int BW = $clog2(PKT_MAX + 1);
   localparam logic [BW-1:0] BCNT_MAX = BW'(PKT_MAX);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_PKT  = 2'd1;
   localparam logic [1:0] ST_DROP = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [BW-1:0]    bcnt_q, bcnt_d, bcnt_inc;
   logic [DW-1:0]    data_q, data_d;
   logic             s_q, s_d;
   logic             valid_q, valid_d;
   logic             last_q, last_d;
   logic             rr_q, rr_d;
   logic             prr_q, prr_d;   // current packet was routed round-robin
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
   logic             xfer, acc, rdy;

   assign xfer     = valid_q & (s_q ? bus.ready1 : bus.ready0);
   // DROP swallows beats without touching the slice, so it is always ready
   assign rdy      = (state_q == ST_DROP) | ~valid_q | xfer;
   assign acc      = bus.in_valid & rdy;
   assign bcnt_inc = bcnt_q + BW'(1);

   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      data_d  = data_q;
      s_d     = s_q;
      valid_d = valid_q;
      last_d  = last_q;
      rr_d    = rr_q;
      prr_d   = prr_q;
      err_d   = err_q;
      cnt0_d  = cnt0_q;
      cnt1_d  = cnt1_q;

      if (xfer) valid_d = 1'b0;
      if (xfer && last_q) begin
         if (s_q) cnt1_d = cnt1_q + CNT_W'(1);
         else     cnt0_d = cnt0_q + CNT_W'(1);
      end

      // a load in the same cycle as xfer overrides the clear above
      if (acc) begin
         case (state_q)
            ST_IDLE: begin
               data_d  = bus.in_data;
               valid_d = 1'b1;
               last_d  = bus.in_last;
               s_d     = mode ? force_sel : rr_q;
               prr_d   = ~mode;
               if (bus.in_last) begin
                  if (!mode) rr_d = ~rr_q;
               end else begin
                  state_d = ST_PKT;
                  bcnt_d  = BW'(1);
               end
            end
            ST_PKT: begin
               data_d  = bus.in_data;
               valid_d = 1'b1;
               last_d  = bus.in_last;
               bcnt_d  = bcnt_inc;
               if (bus.in_last) begin
                  state_d = ST_IDLE;
                  if (prr_q) rr_d = ~rr_q;
               end else if (bcnt_inc == BCNT_MAX) begin
                  // truncate: close the packet here, discard the rest
                  last_d  = 1'b1;
                  err_d   = 1'b1;
                  state_d = ST_DROP;
                  if (prr_q) rr_d = ~rr_q;
               end
            end
            ST_DROP: begin
               if (bus.in_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         bcnt_q  <= '0;
         data_q  <= '0;
         s_q     <= 1'b0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         rr_q    <= 1'b0;
         prr_q   <= 1'b0;
         err_q   <= 1'b0;
         cnt0_q  <= '0;
         cnt1_q  <= '0;
      end else begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
         data_q  <= data_d;
         s_q     <= s_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         rr_q    <= rr_d;
         prr_q   <= prr_d;
         err_q   <= err_d;
         cnt0_q  <= cnt0_d;
         cnt1_q  <= cnt1_d;
      end
   end

   assign bus.in_ready = rdy;
   assign bus.i        = data_q;
   assign bus.s        = s_q;
   assign bus.valid_o  = valid_q;
   assign bus.last_o   = last_q;
   assign pkt_cnt0     = cnt0_q;
   assign pkt_cnt1     = cnt1_q;
   assign pkt_err      = err_q;
endmodule

// File: tb/tb_demux_1x2_pkt_sel.sv
// tb_demux_1x2_pkt_sel
//   Directed bench for demux_1x2_pkt_sel (PKT_MAX=4 so truncation is reachable).
//   Delivered beats are captured as {s,last_o,i} and compared to hand-written lists.
module tb_demux_1x2_pkt_sel;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mode = 1'b0;
   logic       force_sel = 1'b0;
   logic [7:0] pkt_cnt0, pkt_cnt1;
   logic       pkt_err;
   int         n_chk = 0;
   int         n_fail = 0;
   int         w;
   logic [9:0] got_q[$];
   logic [9:0] exp_q[$];

   demux_1x2_pkt_sel_if #(.DW(8)) bus ();

   demux_1x2_pkt_sel #(.DW(8), .PKT_MAX(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .bus(bus), .mode(mode), .force_sel(force_sel),
      .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .pkt_err(pkt_err)
   );

   always #5 clk = ~clk;

   // capture beats that will transfer on the coming rising edge
   always @(negedge clk)
      if (!rst && bus.valid_o && (bus.s ? bus.ready1 : bus.ready0))
         got_q.push_back({bus.s, bus.last_o, bus.i});

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [9:0] bt(input logic s, input logic l, input logic [7:0] d);
      return {s, l, d};
   endfunction

   task automatic send(input logic [7:0] d, input logic l, output int wt);
      bus.in_data = d; bus.in_valid = 1'b1; bus.in_last = l; wt = 0;
      @(negedge clk);
      while (!bus.in_ready && wt < 100) begin wt++; @(negedge clk); end
      if (wt >= 100) chk("send_timeout", 32'(wt), 0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0; bus.in_last = 1'b0;
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0; bus.in_last = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; bus.in_valid = 1'b0; bus.in_last = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      got_q.delete(); exp_q.delete();
   endtask

   task automatic cmp_q(input string tag);
      chk($sformatf("%s_nbeats", tag), 32'(got_q.size()), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size(); k++)
         if (k < got_q.size())
            chk($sformatf("%s_beat%0d", tag, k), 32'(got_q[k]), 32'(exp_q[k]));
      got_q.delete(); exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_data = '0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
      bus.ready0 = 1'b1; bus.ready1 = 1'b1;

      // reset state
      do_reset();
      @(negedge clk);
      chk("rst_valid", 32'(bus.valid_o), 0);
      chk("rst_i", 32'(bus.i), 0);
      chk("rst_s", 32'(bus.s), 0);
      chk("rst_last", 32'(bus.last_o), 0);
      chk("rst_cnt0", 32'(pkt_cnt0), 0);
      chk("rst_cnt1", 32'(pkt_cnt1), 0);
      chk("rst_err", 32'(pkt_err), 0);
      chk("rst_ready", 32'(bus.in_ready), 1);
      @(posedge clk); #1;

      // 1: two 3-beat round-robin packets, streamed back to back
      mode = 1'b0;
      send(8'd1, 1'b0, w);
      chk("t1_lat_valid", 32'(bus.valid_o), 1);
      chk("t1_lat_i", 32'(bus.i), 1);
      for (int k = 2; k <= 6; k++) begin
         send(8'(k), (k % 3) == 0, w);
         chk($sformatf("t1_nobubble%0d", k), 32'(w), 0);
      end
      idle(3);
      exp_q = '{bt(0,0,1), bt(0,0,2), bt(0,1,3), bt(1,0,4), bt(1,0,5), bt(1,1,6)};
      cmp_q("t1");
      chk("t1_cnt0", 32'(pkt_cnt0), 1);
      chk("t1_cnt1", 32'(pkt_cnt1), 1);

      // 2: branch 0 stalls for 5 clocks with the slice full
      do_reset();
      bus.ready0 = 1'b0;
      fork
         begin
            send(8'd1, 1'b0, w);
            send(8'd2, 1'b0, w);
            send(8'd3, 1'b1, w);
            idle(3);
         end
         begin
            @(posedge clk); #1;
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               chk($sformatf("t2_stall_rdy%0d", k), 32'(bus.in_ready), 0);
               chk($sformatf("t2_stall_i%0d", k), 32'(bus.i), 1);
               chk($sformatf("t2_stall_sl%0d", k), 32'({bus.valid_o, bus.s, bus.last_o}), 32'b100);
            end
            @(posedge clk); #1;
            bus.ready0 = 1'b1;
         end
      join
      exp_q = '{bt(0,0,1), bt(0,0,2), bt(0,1,3)};
      cmp_q("t2");
      chk("t2_cnt0", 32'(pkt_cnt0), 1);

      // 3: forced branch 1, mode toggled inside packet 2, then one RR packet
      do_reset();
      mode = 1'b1; force_sel = 1'b1;
      send(8'd20, 1'b0, w); send(8'd21, 1'b1, w);
      send(8'd22, 1'b0, w);
      mode = 1'b0;
      send(8'd23, 1'b1, w);
      mode = 1'b1;
      send(8'd24, 1'b0, w); send(8'd25, 1'b1, w);
      mode = 1'b0;
      send(8'd26, 1'b1, w);
      idle(3);
      exp_q = '{bt(1,0,20), bt(1,1,21), bt(1,0,22), bt(1,1,23), bt(1,0,24), bt(1,1,25), bt(0,1,26)};
      cmp_q("t3");
      chk("t3_cnt1", 32'(pkt_cnt1), 3);
      chk("t3_cnt0", 32'(pkt_cnt0), 1);

      // 4: 6-beat packet truncated at 4 beats
      do_reset();
      for (int k = 10; k <= 15; k++) begin
         send(8'(k), k == 15, w);
         if (k >= 14) chk($sformatf("t4_drop_rdy%0d", k), 32'(w), 0);
      end
      send(8'd30, 1'b1, w);
      idle(3);
      exp_q = '{bt(0,0,10), bt(0,0,11), bt(0,0,12), bt(0,1,13), bt(1,1,30)};
      cmp_q("t4");
      chk("t4_err", 32'(pkt_err), 1);
      chk("t4_cnt0", 32'(pkt_cnt0), 1);
      chk("t4_cnt1", 32'(pkt_cnt1), 1);

      // 5: single-beat packets alternate branches
      do_reset();
      chk("t5_err_cleared", 32'(pkt_err), 0);
      for (int k = 0; k < 4; k++) send(8'(40 + k), 1'b1, w);
      idle(3);
      exp_q = '{bt(0,1,40), bt(1,1,41), bt(0,1,42), bt(1,1,43)};
      cmp_q("t5");
      chk("t5_cnt0", 32'(pkt_cnt0), 2);
      chk("t5_cnt1", 32'(pkt_cnt1), 2);

      // 6: reset on beat 2 of a 4-beat packet
      do_reset();
      send(8'd49, 1'b1, w);
      send(8'd50, 1'b0, w);
      bus.in_data = 8'd51; bus.in_valid = 1'b1; rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("t6_valid", 32'(bus.valid_o), 0);
      chk("t6_cnt0", 32'(pkt_cnt0), 0);
      chk("t6_cnt1", 32'(pkt_cnt1), 0);
      bus.in_valid = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      got_q.delete(); exp_q.delete();
      send(8'd60, 1'b1, w);
      idle(3);
      exp_q = '{bt(0,1,60)};
      cmp_q("t6");
      chk("t6_cnt0_after", 32'(pkt_cnt0), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
